// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: instruction field
// positions, fetch defaults and the fetch FSM state type.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Signal bundle of the fetch stage: instruction memory port, redirect input
// and the decode-facing instruction output.
interface instr_fetch_unit_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  // Handshakes: imem_req stays high with imem_addr stable until the single
  // imem_ack pulse that carries imem_rdata; an instruction transfers to decode
  // on every rising edge where if_valid && dec_ready, unless redirect is high.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic              dec_ready;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [5:0]        op_code;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shamt;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    input  dec_ready,
    output if_valid, if_instr, if_pc, op_code, funct, rs, rt, shamt
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    output dec_ready,
    input  if_valid, if_instr, if_pc, op_code, funct, rs, rt, shamt
  );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs; the head entry is
// read combinationally so a word is visible the cycle after it is written.
module instr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding memory read at a time, buffered
// responses, redirect flush, and decode field slicing of the head word.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  ifu,
  output fetch_state_t        state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + 32;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] redirect_target;
  logic [1:0]        unused_redirect_lsb;

  logic              push;
  logic              pop;
  logic              has_space;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [EW-1:0]     head;
  logic [31:0]       cur_instr;

  assign redirect_target     = {ifu.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ifu.redirect_pc[1:0];

  // A redirect overrides both the response write and the decode pop.
  always_comb begin
    push       = (state == ST_BUSY) && ifu.imem_ack && !ifu.redirect;
    pop        = (count != '0) && ifu.dec_ready && !ifu.redirect;
    count_next = ifu.redirect ? '0 : count + CW'(push) - CW'(pop);
    has_space  = count_next < CW'(DEPTH);
  end

  instr_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (ifu.redirect),
    .wdata ({fetch_pc, ifu.imem_rdata}),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      addr_q   <= addr_next;
    end
  end

  // While BUSY, fetch_pc is the address of the outstanding request; in IDLE
  // and DROP it is the next address to request.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = addr_q;
    case (state)
      ST_IDLE: begin
        if (ifu.redirect) fetch_pc_next = redirect_target;
        if (has_space) begin
          state_next = ST_BUSY;
          addr_next  = fetch_pc_next;
        end
      end
      ST_BUSY: begin
        if (ifu.imem_ack) begin
          fetch_pc_next = ifu.redirect ? redirect_target : fetch_pc + ADDR_W'(4);
          if (has_space) begin
            state_next = ST_BUSY;
            addr_next  = fetch_pc_next;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (ifu.redirect) begin
          state_next    = ST_DROP;
          fetch_pc_next = redirect_target;
        end
      end
      ST_DROP: begin
        if (ifu.redirect) fetch_pc_next = redirect_target;
        // The FIFO was flushed on entry to DROP, so the new request always fits.
        if (ifu.imem_ack) begin
          state_next = ST_BUSY;
          addr_next  = fetch_pc_next;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cur_instr     = (count != '0) ? head[31:0] : 32'h0;
    ifu.imem_req  = (state != ST_IDLE);
    ifu.imem_addr = addr_q;
    ifu.if_valid  = (count != '0);
    ifu.if_instr  = cur_instr;
    ifu.if_pc     = (count != '0) ? head[EW-1:32] : '0;
    ifu.op_code   = cur_instr[OP_MSB:OP_LSB];
    ifu.rs        = cur_instr[RS_MSB:RS_LSB];
    ifu.rt        = cur_instr[RT_MSB:RT_LSB];
    ifu.shamt     = cur_instr[SHAMT_MSB:SHAMT_LSB];
    ifu.funct     = cur_instr[FUNCT_MSB:FUNCT_LSB];
    state_dbg     = state;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirects,
// address wrap and reset during an outstanding request.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  fetch_state_t state_dbg;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) ifu ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifu       (ifu),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mem_auto = 1'b0;
  int acks_given = 0;
  logic [ADDR_W-1:0] exp_q[$];

  // Memory contents: word at address 0 is 0x8D2A34D5
  // (op 0x23, rs 9, rt 10, shamt 0x13, funct 0x15).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8D2A_34D5 ^ (a << 14);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic mem_respond();
    if (mem_auto && ifu.imem_req) begin
      ifu.imem_ack   = 1'b1;
      ifu.imem_rdata = mem_word(ifu.imem_addr);
      acks_given++;
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    ifu.imem_ack = 1'b0;
    ifu.redirect = 1'b0;
    mem_respond();
  endtask

  task automatic ack_with(input logic [31:0] a);
    ifu.imem_ack   = 1'b1;
    ifu.imem_rdata = mem_word(a);
  endtask

  // Leaves the DUT one cycle after release: request for 0x0 outstanding.
  task automatic do_reset();
    rst_n         = 1'b0;
    ifu.imem_ack  = 1'b0;
    ifu.redirect  = 1'b0;
    ifu.dec_ready = 1'b0;
    mem_auto      = 1'b0;
    acks_given    = 0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (ifu.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", ifu.imem_req); end
    checks++; if (ifu.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000000", ifu.imem_addr); end
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifu.if_valid); end
    checks++; if (ifu.if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", ifu.if_instr); end
    checks++; if (ifu.if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", ifu.if_pc); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    rst_n = 1'b1;
    step();
    checks++; if (ifu.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", ifu.imem_req); end
    checks++; if (ifu.imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=00000000", ifu.imem_addr); end
    checks++; if (state_dbg !== ST_BUSY) begin failures++; $display("FAIL first_state got=%0d exp=%0d", state_dbg, ST_BUSY); end
  endtask

  task automatic test_stream();
    logic [ADDR_W-1:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    ifu.dec_ready = 1'b1;
    mem_auto      = 1'b1;
    mem_respond();
    step();
    checks++; if (ifu.op_code !== 6'h23) begin failures++; $display("FAIL field_op got=%h exp=23", ifu.op_code); end
    checks++; if (ifu.rs !== 5'd9) begin failures++; $display("FAIL field_rs got=%h exp=09", ifu.rs); end
    checks++; if (ifu.rt !== 5'd10) begin failures++; $display("FAIL field_rt got=%h exp=0a", ifu.rt); end
    checks++; if (ifu.shamt !== 5'h13) begin failures++; $display("FAIL field_shamt got=%h exp=13", ifu.shamt); end
    checks++; if (ifu.funct !== 6'h15) begin failures++; $display("FAIL field_funct got=%h exp=15", ifu.funct); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++; if (ifu.if_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, ifu.if_valid); end
      checks++; if (ifu.if_pc !== e) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, ifu.if_pc, e); end
      checks++; if (ifu.if_instr !== mem_word(e)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, ifu.if_instr, mem_word(e)); end
      step();
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    mem_auto = 1'b1;
    mem_respond();
    for (int i = 0; i < 8; i++) step();
    checks++; if (acks_given != 4) begin failures++; $display("FAIL stall_acks got=%0d exp=4", acks_given); end
    checks++; if (ifu.imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", ifu.imem_req); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL stall_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    ifu.dec_ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if (ifu.if_pc !== e) begin failures++; $display("FAIL stall_head got=%h exp=%h", ifu.if_pc, e); end
    step();
    checks++; if (ifu.imem_req !== 1'b1) begin failures++; $display("FAIL resume_req got=%b exp=1", ifu.imem_req); end
    checks++; if (ifu.imem_addr !== 32'h10) begin failures++; $display("FAIL resume_addr got=%h exp=00000010", ifu.imem_addr); end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      if (ifu.if_valid) begin
        e = exp_q.pop_front();
        checks++; if (ifu.if_pc !== e) begin failures++; $display("FAIL drain_pc got=%h exp=%h", ifu.if_pc, e); end
      end
      step();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    ifu.dec_ready = 1'b1;
    ack_with(32'h0);
    step();
    ack_with(32'h4);
    step();
    ifu.redirect    = 1'b1;
    ifu.redirect_pc = 32'h100;
    step();
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rdi_valid got=%b exp=0", ifu.if_valid); end
    checks++; if (ifu.imem_addr !== 32'h8) begin failures++; $display("FAIL rdi_hold_addr got=%h exp=00000008", ifu.imem_addr); end
    checks++; if (state_dbg !== ST_DROP) begin failures++; $display("FAIL rdi_state got=%0d exp=%0d", state_dbg, ST_DROP); end
    step();
    step();
    checks++; if (ifu.imem_req !== 1'b1) begin failures++; $display("FAIL rdi_req_held got=%b exp=1", ifu.imem_req); end
    ack_with(32'h8);
    step();
    checks++; if (ifu.imem_addr !== 32'h100) begin failures++; $display("FAIL rdi_new_addr got=%h exp=00000100", ifu.imem_addr); end
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rdi_discard got=%b exp=0", ifu.if_valid); end
    ack_with(32'h100);
    step();
    checks++; if (ifu.if_pc !== 32'h100) begin failures++; $display("FAIL rdi_pc got=%h exp=00000100", ifu.if_pc); end
    checks++; if (ifu.if_instr !== mem_word(32'h100)) begin failures++; $display("FAIL rdi_instr got=%h exp=%h", ifu.if_instr, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    ifu.dec_ready   = 1'b1;
    ack_with(32'h0);
    ifu.redirect    = 1'b1;
    ifu.redirect_pc = 32'h203;
    step();
    checks++; if (ifu.imem_addr !== 32'h200) begin failures++; $display("FAIL rda_addr got=%h exp=00000200", ifu.imem_addr); end
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rda_valid got=%b exp=0", ifu.if_valid); end
    ack_with(32'h200);
    step();
    checks++; if (ifu.if_pc !== 32'h200) begin failures++; $display("FAIL rda_pc got=%h exp=00000200", ifu.if_pc); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    ack_with(32'h0);
    step();
    ack_with(32'h4);
    step();
    ack_with(32'h8);
    step();
    checks++; if (ifu.if_pc !== 32'h0) begin failures++; $display("FAIL rdp_head got=%h exp=00000000", ifu.if_pc); end
    ifu.redirect    = 1'b1;
    ifu.redirect_pc = 32'h40;
    ifu.dec_ready   = 1'b1;
    step();
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rdp_flush got=%b exp=0", ifu.if_valid); end
    checks++; if (state_dbg !== ST_DROP) begin failures++; $display("FAIL rdp_state got=%0d exp=%0d", state_dbg, ST_DROP); end
    ifu.redirect    = 1'b1;
    ifu.redirect_pc = 32'h84;
    step();
    ack_with(32'hC);
    step();
    checks++; if (ifu.imem_addr !== 32'h84) begin failures++; $display("FAIL rdp_addr got=%h exp=00000084", ifu.imem_addr); end
    ack_with(32'h84);
    step();
    checks++; if (ifu.if_pc !== 32'h84) begin failures++; $display("FAIL rdp_pc got=%h exp=00000084", ifu.if_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    ack_with(32'h0);
    ifu.redirect    = 1'b1;
    ifu.redirect_pc = 32'hFFFF_FFFE;
    step();
    checks++; if (ifu.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%h exp=fffffffc", ifu.imem_addr); end
    ack_with(32'hFFFF_FFFC);
    step();
    checks++; if (ifu.if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", ifu.if_pc); end
    checks++; if (ifu.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", ifu.imem_addr); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    ack_with(32'h0);
    step();
    rst_n = 1'b0;
    step();
    checks++; if (ifu.imem_req !== 1'b0) begin failures++; $display("FAIL rstb_req got=%b exp=0", ifu.imem_req); end
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rstb_valid got=%b exp=0", ifu.if_valid); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL rstb_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    ack_with(32'h4);
    step();
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rstb_ack_in_reset got=%b exp=0", ifu.if_valid); end
    rst_n = 1'b1;
    ack_with(32'h8);
    step();
    checks++; if (ifu.if_valid !== 1'b0) begin failures++; $display("FAIL rstb_late_ack got=%b exp=0", ifu.if_valid); end
    checks++; if (ifu.imem_req !== 1'b1) begin failures++; $display("FAIL rstb_req_after got=%b exp=1", ifu.imem_req); end
    checks++; if (ifu.imem_addr !== 32'h0) begin failures++; $display("FAIL rstb_addr_after got=%h exp=00000000", ifu.imem_addr); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ifu.imem_ack    = 1'b0;
    ifu.imem_rdata  = 32'h0;
    ifu.redirect    = 1'b0;
    ifu.redirect_pc = 32'h0;
    ifu.dec_ready   = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_ack();
    test_redirect_pop();
    test_wrap();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
